// File: rtl/arb_mux.sv
// Registered round-robin N:1 arbitrated mux with valid/ready on each side.
// Optional burst locking via ARB_MUX_LOCK_EN (adds in_last, drives out_last).
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
`ifdef ARB_MUX_LOCK_EN
  input  logic [N-1:0]       in_last,
`endif
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic             can_load, accept, grant_any;
  logic [SEL_W-1:0] grant_idx;
  logic [N-1:0]     grant_oh;

  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % N;
    return s[SEL_W-1:0];
  endfunction

`ifdef ARB_MUX_LOCK_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic             out_last_q, out_last_d;
`endif

  assign can_load = !out_valid_q || out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_any = 1'b0;
    grant_idx = '0;
`ifdef ARB_MUX_LOCK_EN
    if (lock_q) begin
      grant_any = in_valid[lock_ch_q];
      grant_idx = lock_ch_q;
    end else
`endif
    begin
      for (int k = 0; k < N; k++) begin
        if (!grant_any && in_valid[wrap_add(ptr_q, k)]) begin
          grant_any = 1'b1;
          grant_idx = wrap_add(ptr_q, k);
        end
      end
    end
    grant_oh = '0;
    if (grant_any) grant_oh[grant_idx] = 1'b1;
  end

  // rst_n gates in_ready so nothing looks accepted while reset is held.
  assign in_ready = grant_oh & {N{can_load & rst_n}};
  assign accept   = grant_any & can_load;

  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
`ifdef ARB_MUX_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    out_last_d  = out_last_q;
`endif
    if (accept) begin
      out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      ptr_d       = wrap_add(grant_idx, 1);
`ifdef ARB_MUX_LOCK_EN
      out_last_d  = in_last[grant_idx];
      lock_d      = !in_last[grant_idx];
      lock_ch_d   = grant_idx;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef ARB_MUX_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
`ifdef ARB_MUX_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
`ifdef ARB_MUX_LOCK_EN
  assign out_last  = out_last_q;
`else
  assign out_last  = 1'b1;
`endif

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux (N=4): stimulus pushes expected beats,
// a negedge monitor pops and compares each beat the DUT hands downstream.
module tb_arb_mux;
  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   in_last;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   sel;
    logic         last;
  } beat_t;

  beat_t q[$];
  int checks = 0;
  int errors = 0;

  arb_mux #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready),
`ifdef ARB_MUX_LOCK_EN
    .in_last(in_last),
`endif
    .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input logic [1:0] s, input logic l);
    beat_t b;
    b.data = d; b.sel = s; b.last = l;
    q.push_back(b);
  endtask

  task automatic set_data(input int ch, input logic [W-1:0] d);
    in_data[ch*W +: W] = d;
  endtask

  // Monitor: a beat transfers when out_valid & out_ready at the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_beat", {16'h0, out_data}, 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = q.pop_front();
        check("beat_data", {16'h0, out_data}, {16'h0, e.data});
        check("beat_sel", {30'h0, out_sel}, {30'h0, e.sel});
        check("beat_last", {31'h0, out_last}, {31'h0, e.last});
      end
    end
  end

  initial begin
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, 16'(16'hA0 + i));

    // Reset held with every channel requesting.
    repeat (2) step();
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_in_ready", {28'h0, in_ready}, 32'h0);
    check("rst_out_data", {16'h0, out_data}, 32'h0);
    check("rst_out_sel", {30'h0, out_sel}, 32'h0);

    // Round robin: two full rotations, then backpressure on the ch2 beat.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(16'(16'hA0 + i), 2'(i), 1'b1);
    rst_n = 1'b1;
    #1 check("first_grant", {28'h0, in_ready}, 32'h1);
    repeat (7) step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #3;
      check("bp_data", {16'h0, out_data}, 32'hA2);
      check("bp_sel", {30'h0, out_sel}, 32'h2);
      check("bp_in_ready", {28'h0, in_ready}, 32'h0);
      check("bp_valid", {31'h0, out_valid}, 32'h1);
      step();
    end
    out_ready = 1'b1;
    #1 check("bp_next_grant", {28'h0, in_ready}, 32'h8);
    step();
    in_valid = 4'b0000;
    step();
    check("drain_valid", {31'h0, out_valid}, 32'h0);

    // Sparse: ch1 alone (ptr 0 -> 2), then ch1 alone again with ptr 2 (wrap).
    push(16'hA1, 2'd1, 1'b1);
    push(16'hB1, 2'd1, 1'b1);
    push(16'hA2, 2'd2, 1'b1);
    in_valid = 4'b0010;
    #1 check("sparse_grant0", {28'h0, in_ready}, 32'h2);
    step();
    set_data(1, 16'hB1);
    check("sparse_grant_wrap", {28'h0, in_ready}, 32'h2);
    step();
    in_valid = 4'b1111;
    #1 check("sparse_ptr2", {28'h0, in_ready}, 32'h4);
    step();
    in_valid = 4'b0000;
    step();

`ifdef ARB_MUX_LOCK_EN
    // Locked 3-beat burst on ch0 while ch1 also requests; ptr is 3 here.
    push(16'hC0, 2'd0, 1'b0);
    push(16'hC1, 2'd0, 1'b0);
    push(16'hC2, 2'd0, 1'b1);
    push(16'hD1, 2'd1, 1'b1);
    set_data(0, 16'hC0);
    set_data(1, 16'hD1);
    in_last  = 4'b0010;
    in_valid = 4'b0011;
    step();
    set_data(0, 16'hC1);
    #1 check("lock_blocks_ch1", {28'h0, in_ready}, 32'h1);
    step();
    set_data(0, 16'hC2);
    in_last = 4'b0011;
    step();
    in_valid = 4'b0010;
    #1 check("unlock_ch1", {28'h0, in_ready}, 32'h2);
    step();
    in_valid = 4'b0000;
    step();
    in_last = 4'b0000;
`endif

    // Reset while a beat is stalled in the output register.
    out_ready = 1'b0;
    set_data(0, 16'hE0);
    in_valid = 4'b0001;
    step();
    check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    #1 rst_n = 1'b0;
    #1 check("async_rst_valid", {31'h0, out_valid}, 32'h0);
    check("async_rst_in_ready", {28'h0, in_ready}, 32'h0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_last = 4'b1111;
    set_data(1, 16'hF1);
    in_valid = 4'b0010;
    push(16'hF1, 2'd1, 1'b1);
    #1 check("post_rst_unlocked", {28'h0, in_ready}, 32'h2);
    step();
    in_valid = 4'b0011;
    #1 check("post_rst_ptr", {28'h0, in_ready}, 32'h1);
    in_valid = 4'b0000;

    for (int t = 0; t < 20 && q.size() != 0; t++) step();
    step();
    check("scoreboard_empty", q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
